// File: rtl/keccak_pkg.sv
// Shared constants and FSM state type for the Keccak absorb path.
package keccak_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_WR   = 3'd2,
        ST_PERM = 3'd3,
        ST_PAD  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Rate in 64-bit lanes per variant.
    localparam int unsigned RATE_SHAKE128 = 21;
    localparam int unsigned RATE_SHA3_256 = 17;
    localparam int unsigned RATE_SHA3_512 = 9;

    // Domain-separation bytes and the final pad bit.
    localparam logic [7:0] DSEP_SHAKE = 8'h1F;
    localparam logic [7:0] DSEP_SHA3  = 8'h06;
    localparam logic [7:0] PAD_LAST   = 8'h80;

endpackage

// File: rtl/load64.sv
// Byte-order converter: arrival-order buffer (first byte at [63:56]) to a
// little-endian lane (byte k at [8k+7:8k]).
module load64 (
    input  logic [63:0] lane_buf,
    output logic [63:0] lane
);

    // Reverse byte order across the word.
    for (genvar k = 0; k < 8; k++) begin : g_byte
        assign lane[8*k +: 8] = lane_buf[8*(7-k) +: 8];
    end

endmodule

// File: rtl/keccak_absorb_ctrl.sv
// Absorb sequencer: packs message bytes into lanes, issues lane-XOR writes,
// requests a permutation per full rate block and applies final padding.
module keccak_absorb_ctrl
    import keccak_pkg::*;
#(
    parameter int unsigned BW_DATA    = 64,
    parameter int unsigned RATE_LANES = RATE_SHAKE128,
    parameter logic [7:0]  DSEP       = DSEP_SHAKE
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_init,
    input  logic               i_byte_valid,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_last,
    output logic               o_byte_ready,
    output logic               o_lane_we,
    output logic [4:0]         o_lane_idx,
    output logic [BW_DATA-1:0] o_lane_data,
    output logic               o_perm_start,
    input  logic               i_perm_done,
    output logic               o_done
);

    localparam logic [4:0]         LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [BW_DATA-1:0] PAD_WORD  = {PAD_LAST, {(BW_DATA-8){1'b0}}};

    state_e               state_q, state_d;
    logic [2:0]           bpos_q, bpos_d;
    logic [4:0]           lidx_q, lidx_d;
    logic [BW_DATA-1:0]   lane_buf_q, lane_buf_d;
    logic                 last_q, last_d;
    logic                 pad2_q, pad2_d;
    logic [BW_DATA-1:0]   l64_in, l64_out;
    logic                 ready_d, we_d, perm_d, done_d;
    logic [4:0]           idx_d;
    logic [BW_DATA-1:0]   data_d;

    // Next-state and counter/buffer update.
    always_comb begin
        state_d    = state_q;
        bpos_d     = bpos_q;
        lidx_d     = lidx_q;
        lane_buf_d = lane_buf_q;
        last_d     = last_q;
        pad2_d     = pad2_q;
        if (i_init) begin
            state_d    = ST_ACC;
            bpos_d     = 3'd0;
            lidx_d     = 5'd0;
            lane_buf_d = '0;
            last_d     = 1'b0;
            pad2_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (i_byte_valid && o_byte_ready) begin
                        lane_buf_d[{3'd7 - bpos_q, 3'd0} +: 8] = i_byte;
                        if (bpos_q == 3'd7) begin
                            state_d = ST_WR;
                            last_d  = i_byte_last;
                        end else begin
                            bpos_d = bpos_q + 3'd1;
                            if (i_byte_last) state_d = ST_PAD;
                        end
                    end
                end
                ST_WR: begin
                    bpos_d     = 3'd0;
                    lane_buf_d = '0;
                    if (lidx_q == LAST_LANE) begin
                        lidx_d  = 5'd0;
                        state_d = ST_PERM;
                    end else begin
                        lidx_d  = lidx_q + 5'd1;
                        state_d = last_q ? ST_PAD : ST_ACC;
                    end
                end
                ST_PERM: begin
                    if (i_perm_done) state_d = last_q ? ST_PAD : ST_ACC;
                end
                ST_PAD: begin
                    if (pad2_q || (lidx_q == LAST_LANE)) begin
                        state_d = ST_DONE;
                        pad2_d  = 1'b0;
                    end else begin
                        pad2_d = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Lane converter input: buffered bytes, plus DSEP at the fill point when padding.
    always_comb begin
        l64_in = lane_buf_d;
        if (state_d == ST_PAD) l64_in[{3'd7 - bpos_d, 3'd0} +: 8] = DSEP;
    end

    load64 u_load64 (
        .lane_buf (l64_in),
        .lane     (l64_out)
    );

    // Output decode from the upcoming state so outputs line up with it once registered.
    always_comb begin
        ready_d = (state_d == ST_ACC);
        we_d    = (state_d == ST_WR) || (state_d == ST_PAD);
        perm_d  = (state_d == ST_WR) && (lidx_d == LAST_LANE);
        done_d  = (state_d == ST_DONE);
        idx_d   = 5'd0;
        data_d  = '0;
        if (state_d == ST_WR) begin
            idx_d  = lidx_d;
            data_d = l64_out;
        end else if (state_d == ST_PAD) begin
            if (pad2_d) begin
                idx_d  = LAST_LANE;
                data_d = PAD_WORD;
            end else begin
                idx_d  = lidx_d;
                data_d = (lidx_d == LAST_LANE) ? (l64_out ^ PAD_WORD) : l64_out;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            bpos_q       <= 3'd0;
            lidx_q       <= 5'd0;
            lane_buf_q   <= '0;
            last_q       <= 1'b0;
            pad2_q       <= 1'b0;
            o_byte_ready <= 1'b0;
            o_lane_we    <= 1'b0;
            o_lane_idx   <= 5'd0;
            o_lane_data  <= '0;
            o_perm_start <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bpos_q       <= bpos_d;
            lidx_q       <= lidx_d;
            lane_buf_q   <= lane_buf_d;
            last_q       <= last_d;
            pad2_q       <= pad2_d;
            o_byte_ready <= ready_d;
            o_lane_we    <= we_d;
            o_lane_idx   <= idx_d;
            o_lane_data  <= data_d;
            o_perm_start <= perm_d;
            o_done       <= done_d;
        end
    end

endmodule
